// File: rtl/sobel_edge_stream.sv
// sobel_edge_stream: streaming RGB -> grey -> 3x3 Sobel edge magnitude.
// One pixel in per in_valid, one pixel out exactly three cycles later.
// Two line buffers hold the previous two grey rows. A two-column shift
// window combined with the current column forms the 3x3 neighbourhood.
// Output modes are grey bypass, saturated magnitude and thresholded binary.
// The mode is sampled per pixel and carried down the pipeline.
// A per-frame cycle counter reports the length of every completed frame.
module sobel_edge_stream #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = 8,
    parameter int CYC_W      = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             edge_en,
    input  logic             bin_mode,
    input  logic [PIX_W-1:0] thresh,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_R,
    input  logic [PIX_W-1:0] in_G,
    input  logic [PIX_W-1:0] in_B,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_eof,
    output logic [PIX_W-1:0] edge_out,
    output logic [CYC_W-1:0] frame_cycles,
    output logic             frame_done
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int SUM_W = PIX_W + 2;   // grey accumulator width
    localparam int GRD_W = PIX_W + 4;   // signed gradient width

    localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};
    localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [CYC_W-1:0] CYC_ZERO = {CYC_W{1'b0}};
    localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
    localparam logic [CYC_W-1:0] CYC_MAX  = {CYC_W{1'b1}};
    localparam logic [PIX_W-1:0] PIX_ZERO = {PIX_W{1'b0}};
    localparam logic [PIX_W-1:0] PIX_MAX  = {PIX_W{1'b1}};
    localparam logic [GRD_W-1:0] GRD_ZERO = {GRD_W{1'b0}};

    // (R + 2G + B) / 4, with the sum kept wide enough to avoid overflow
    function automatic logic [PIX_W-1:0] grey_of(input logic [PIX_W-1:0] r,
                                                 input logic [PIX_W-1:0] g,
                                                 input logic [PIX_W-1:0] b);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(r) + {1'b0, g, 1'b0} + SUM_W'(b);
        return PIX_W'(sum >> 2);
    endfunction

    // 1-2-1 weighted sum of three pixels, as a signed gradient operand
    function automatic logic signed [GRD_W-1:0] wsum(input logic [PIX_W-1:0] a,
                                                     input logic [PIX_W-1:0] b,
                                                     input logic [PIX_W-1:0] c);
        logic [GRD_W-1:0] s;
        s = GRD_W'(a) + GRD_W'({b, 1'b0}) + GRD_W'(c);
        return $signed(s);
    endfunction

    // absolute value; the most negative code never occurs for 3x3 Sobel
    function automatic logic [GRD_W-1:0] abs_of(input logic signed [GRD_W-1:0] v);
        logic [GRD_W-1:0] r;
        if (v[GRD_W-1]) begin
            r = $unsigned(-v);
        end else begin
            r = $unsigned(v);
        end
        return r;
    endfunction

    // clamp the magnitude to the output pixel range
    function automatic logic [PIX_W-1:0] sat_mag(input logic [GRD_W:0] m);
        logic [PIX_W-1:0] r;
        if (|m[GRD_W:PIX_W]) begin
            r = PIX_MAX;
        end else begin
            r = m[PIX_W-1:0];
        end
        return r;
    endfunction

    // ---------------- input position and line buffers ----------------
    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    logic [COL_W-1:0] cur_col_s, nxt_col_s;
    logic [ROW_W-1:0] cur_row_s, nxt_row_s;
    logic             pos_sof_s, pos_eof_s, pos_mask_s;
    logic [PIX_W-1:0] grey_s, lb1_rd_s, lb2_rd_s;

    logic [PIX_W-1:0] lb1_r [IMG_WIDTH];  // row r-1
    logic [PIX_W-1:0] lb2_r [IMG_WIDTH];  // row r-2

    // Position of the pixel on the input and the position that follows it
    always_comb begin
        cur_col_s = col_r;
        cur_row_s = row_r;
        nxt_col_s = COL_ZERO;
        nxt_row_s = ROW_ZERO;
        if (in_sof) begin
            cur_col_s = COL_ZERO;
            cur_row_s = ROW_ZERO;
        end else begin
            cur_col_s = col_r;
            cur_row_s = row_r;
        end
        if (cur_col_s == COL_LAST) begin
            nxt_col_s = COL_ZERO;
            if (cur_row_s == ROW_LAST) begin
                nxt_row_s = ROW_ZERO;
            end else begin
                nxt_row_s = cur_row_s + ROW_ONE;
            end
        end else begin
            nxt_col_s = cur_col_s + COL_ONE;
            nxt_row_s = cur_row_s;
        end
    end

    assign pos_sof_s  = (cur_col_s == COL_ZERO) && (cur_row_s == ROW_ZERO);
    assign pos_eof_s  = (cur_col_s == COL_LAST) && (cur_row_s == ROW_LAST);
    assign pos_mask_s = (cur_row_s < ROW_TWO) || (cur_col_s < COL_TWO);
    assign grey_s     = grey_of(in_R, in_G, in_B);
    assign lb1_rd_s   = lb1_r[cur_col_s];
    assign lb2_rd_s   = lb2_r[cur_col_s];

    // Column/row counters advance on every accepted pixel and wrap at frame end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r <= COL_ZERO;
            row_r <= ROW_ZERO;
        end else if (in_valid) begin
            col_r <= nxt_col_s;
            row_r <= nxt_row_s;
        end
    end

    // Line buffers shift one row down at the current column; contents are not reset
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb1_r[cur_col_s] <= grey_s;
            lb2_r[cur_col_s] <= lb1_rd_s;
        end
    end

    // ---------------- frame cycle counter ----------------
    logic [CYC_W-1:0] cyc_r, cyc_inc_s, cnt_cap_r;

    // Saturating increment of the running frame count
    always_comb begin
        cyc_inc_s = cyc_r;
        if (cyc_r == CYC_MAX) begin
            cyc_inc_s = cyc_r;
        end else begin
            cyc_inc_s = cyc_r + CYC_ONE;
        end
    end

    // Count restarts at 1 on a frame's first pixel; the final count is captured at its last pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_r     <= CYC_ZERO;
            cnt_cap_r <= CYC_ZERO;
        end else begin
            if (in_valid && pos_sof_s) begin
                cyc_r <= CYC_ONE;
            end else begin
                cyc_r <= cyc_inc_s;
            end
            if (in_valid && pos_eof_s) begin
                cnt_cap_r <= cyc_inc_s;
            end
        end
    end

    // ---------------- stage 1: grey + line-buffer read ----------------
    logic             s1_valid_r, s1_sof_r, s1_eof_r, s1_mask_r;
    logic             s1_edge_en_r, s1_bin_r;
    logic [PIX_W-1:0] s1_thresh_r, s1_grey_r, s1_mid_r, s1_top_r;

    // Capture the new pixel's column of three plus its markers and mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r   <= 1'b0;
            s1_sof_r     <= 1'b0;
            s1_eof_r     <= 1'b0;
            s1_mask_r    <= 1'b0;
            s1_edge_en_r <= 1'b0;
            s1_bin_r     <= 1'b0;
            s1_thresh_r  <= PIX_ZERO;
            s1_grey_r    <= PIX_ZERO;
            s1_mid_r     <= PIX_ZERO;
            s1_top_r     <= PIX_ZERO;
        end else begin
            s1_valid_r <= in_valid;
            s1_sof_r   <= in_valid && pos_sof_s;
            s1_eof_r   <= in_valid && pos_eof_s;
            if (in_valid) begin
                s1_mask_r    <= pos_mask_s;
                s1_edge_en_r <= edge_en;
                s1_bin_r     <= bin_mode;
                s1_thresh_r  <= thresh;
                s1_grey_r    <= grey_s;
                s1_mid_r     <= lb1_rd_s;
                s1_top_r     <= lb2_rd_s;
            end
        end
    end

    // ---------------- stage 2: window shift + gradients ----------------
    logic [PIX_W-1:0]        win_m_top_r, win_m_mid_r, win_m_bot_r;
    logic [PIX_W-1:0]        win_l_top_r, win_l_mid_r, win_l_bot_r;
    logic signed [GRD_W-1:0] gx_s, gy_s, s2_gx_r, s2_gy_r;
    logic                    s2_valid_r, s2_sof_r, s2_eof_r, s2_mask_r;
    logic                    s2_edge_en_r, s2_bin_r;
    logic [PIX_W-1:0]        s2_thresh_r, s2_grey_r;

    // Right column is the stage-1 column; middle and left come from the window
    assign gx_s = wsum(s1_top_r, s1_mid_r, s1_grey_r)
                - wsum(win_l_top_r, win_l_mid_r, win_l_bot_r);
    assign gy_s = wsum(win_l_bot_r, win_m_bot_r, s1_grey_r)
                - wsum(win_l_top_r, win_m_top_r, s1_top_r);

    // Shift the window by one column per valid pixel and register the gradients
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_m_top_r  <= PIX_ZERO;
            win_m_mid_r  <= PIX_ZERO;
            win_m_bot_r  <= PIX_ZERO;
            win_l_top_r  <= PIX_ZERO;
            win_l_mid_r  <= PIX_ZERO;
            win_l_bot_r  <= PIX_ZERO;
            s2_gx_r      <= GRD_ZERO;
            s2_gy_r      <= GRD_ZERO;
            s2_valid_r   <= 1'b0;
            s2_sof_r     <= 1'b0;
            s2_eof_r     <= 1'b0;
            s2_mask_r    <= 1'b0;
            s2_edge_en_r <= 1'b0;
            s2_bin_r     <= 1'b0;
            s2_thresh_r  <= PIX_ZERO;
            s2_grey_r    <= PIX_ZERO;
        end else begin
            s2_valid_r <= s1_valid_r;
            s2_sof_r   <= s1_sof_r;
            s2_eof_r   <= s1_eof_r;
            if (s1_valid_r) begin
                win_l_top_r  <= win_m_top_r;
                win_l_mid_r  <= win_m_mid_r;
                win_l_bot_r  <= win_m_bot_r;
                win_m_top_r  <= s1_top_r;
                win_m_mid_r  <= s1_mid_r;
                win_m_bot_r  <= s1_grey_r;
                s2_gx_r      <= gx_s;
                s2_gy_r      <= gy_s;
                s2_mask_r    <= s1_mask_r;
                s2_edge_en_r <= s1_edge_en_r;
                s2_bin_r     <= s1_bin_r;
                s2_thresh_r  <= s1_thresh_r;
                s2_grey_r    <= s1_grey_r;
            end
        end
    end

    // ---------------- stage 3: magnitude, threshold, mask ----------------
    logic [GRD_W:0]   mag_s;
    logic [PIX_W-1:0] mag_sat_s, result_s;

    assign mag_s     = {1'b0, abs_of(s2_gx_r)} + {1'b0, abs_of(s2_gy_r)};
    assign mag_sat_s = sat_mag(mag_s);

    // Select grey bypass, border zero, binary or saturated magnitude
    always_comb begin
        result_s = PIX_ZERO;
        if (!s2_edge_en_r) begin
            result_s = s2_grey_r;
        end else if (s2_mask_r) begin
            result_s = PIX_ZERO;
        end else if (s2_bin_r) begin
            if (mag_sat_s >= s2_thresh_r) begin
                result_s = PIX_MAX;
            end else begin
                result_s = PIX_ZERO;
            end
        end else begin
            result_s = mag_sat_s;
        end
    end

    logic             out_valid_r, out_sof_r, out_eof_r, frame_done_r;
    logic [PIX_W-1:0] edge_out_r;
    logic [CYC_W-1:0] frame_cycles_r;

    // Output registers; the frame count is published together with the last output pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r    <= 1'b0;
            out_sof_r      <= 1'b0;
            out_eof_r      <= 1'b0;
            frame_done_r   <= 1'b0;
            edge_out_r     <= PIX_ZERO;
            frame_cycles_r <= CYC_ZERO;
        end else begin
            out_valid_r  <= s2_valid_r;
            out_sof_r    <= s2_sof_r;
            out_eof_r    <= s2_eof_r;
            frame_done_r <= s2_eof_r;
            if (s2_valid_r) begin
                edge_out_r <= result_s;
            end
            if (s2_eof_r) begin
                frame_cycles_r <= cnt_cap_r;
            end
        end
    end

    assign out_valid    = out_valid_r;
    assign out_sof      = out_sof_r;
    assign out_eof      = out_eof_r;
    assign edge_out     = edge_out_r;
    assign frame_cycles = frame_cycles_r;
    assign frame_done   = frame_done_r;

endmodule
